// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the stage control
// bundle and bit positions within it.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [4:0] en;     // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [3:0] flush;  // {if_id, id_ex, ex_mem, mem_wb}
    } stage_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int EN_PC     = 4;
    localparam int EN_IF_ID  = 3;
    localparam int EN_ID_EX  = 2;
    localparam int EN_EX_MEM = 1;
    localparam int EN_MEM_WB = 0;

    localparam int FL_IF_ID  = 3;
    localparam int FL_ID_EX  = 2;
    localparam int FL_EX_MEM = 1;
    localparam int FL_MEM_WB = 0;

    localparam stage_ctrl_t CTRL_RUN    = '{en: 5'b11111, flush: 4'b0000};
    // Full freeze still bubbles MEM/WB so the stalled access is not retired twice.
    localparam stage_ctrl_t CTRL_FREEZE = '{en: 5'b00000, flush: 4'b0001};
    localparam stage_ctrl_t CTRL_IDLE   = '{en: 5'b00000, flush: 4'b0000};

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard  = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, fetch wait and
// data-memory wait with timeout. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              mem_fault,
    output logic [1:0]        state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_events,
    output logic [PERF_W-1:0] perf_mem_wait_cycles
`endif
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_fault_q, mem_fault_d;
    logic             hazard;
    stage_ctrl_t      run_ctrl, ctrl, ctrl_o;

    load_use_detect u_load_use (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    // Control as seen when no memory stall is in effect (RUN, or MEM_WAIT on its ack cycle).
    always_comb begin
        run_ctrl = CTRL_RUN;
        if (ex_branch_taken) begin
            run_ctrl.flush[FL_IF_ID] = 1'b1;
            run_ctrl.flush[FL_ID_EX] = 1'b1;
        end else if (hazard) begin
            run_ctrl.en[EN_PC]       = 1'b0;
            run_ctrl.en[EN_IF_ID]    = 1'b0;
            run_ctrl.flush[FL_ID_EX] = 1'b1;
        end else if (!imem_ready) begin
            run_ctrl.en[EN_PC]       = 1'b0;
            run_ctrl.flush[FL_IF_ID] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        ctrl        = run_ctrl;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    ctrl        = CTRL_FREEZE;
                    state_d     = FAULT;
                    mem_fault_d = 1'b1;
                end else begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            FAULT: begin
                ctrl = CTRL_IDLE;
            end
            default: begin
                ctrl    = CTRL_IDLE;
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign ctrl_o = reset ? CTRL_IDLE : ctrl;

    assign pc_en        = ctrl_o.en[EN_PC];
    assign if_id_en     = ctrl_o.en[EN_IF_ID];
    assign id_ex_en     = ctrl_o.en[EN_ID_EX];
    assign ex_mem_en    = ctrl_o.en[EN_EX_MEM];
    assign mem_wb_en    = ctrl_o.en[EN_MEM_WB];
    assign if_id_flush  = ctrl_o.flush[FL_IF_ID];
    assign id_ex_flush  = ctrl_o.flush[FL_ID_EX];
    assign ex_mem_flush = ctrl_o.flush[FL_EX_MEM];
    assign mem_wb_flush = ctrl_o.flush[FL_MEM_WB];
    assign mem_fault    = mem_fault_q;
    assign state_o      = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_W-1:0] perf_mw_q, perf_mw_d;
    logic              branch_flush;

    // Only the branch rule bubbles IF/ID and ID/EX together.
    assign branch_flush = ctrl.flush[FL_IF_ID] && ctrl.flush[FL_ID_EX];

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_mw_d    = perf_mw_q;
        if (!ctrl.en[EN_PC])      perf_stall_d = perf_stall_q + PERF_W'(1);
        if (branch_flush)         perf_flush_d = perf_flush_q + PERF_W'(1);
        if (state_q == MEM_WAIT)  perf_mw_d    = perf_mw_q + PERF_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_mw_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mw_q    <= perf_mw_d;
        end
    end

    assign perf_stall_cycles    = perf_stall_q;
    assign perf_flush_events    = perf_flush_q;
    assign perf_mem_wait_cycles = perf_mw_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares the combinational controls, state and fault flag.
module tb_pipeline_stall_ctrl;

    localparam logic [7:0] F_RST = 8'h80;
    localparam logic [7:0] F_IR  = 8'h40;
    localparam logic [7:0] F_U1  = 8'h20;
    localparam logic [7:0] F_U2  = 8'h10;
    localparam logic [7:0] F_MR  = 8'h08;
    localparam logic [7:0] F_BR  = 8'h04;
    localparam logic [7:0] F_RQ  = 8'h02;
    localparam logic [7:0] F_AK  = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_ready, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ack;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       mem_fault;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_events, perf_mem_wait_cycles;
`endif

    typedef struct {
        string       name;
        logic [11:0] v;
        bit          chk_perf;
        logic [31:0] p_stall;
        logic [31:0] p_flush;
        logic [31:0] p_mw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .PERF_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_ready      (imem_ready),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_fault       (mem_fault),
        .state_o         (state_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_flush_events    (perf_flush_events),
        .perf_mem_wait_cycles (perf_mem_wait_cycles)
`endif
    );

    // Drive one cycle of inputs just after the rising edge and queue the expected response.
    task automatic vec(input string nm, input logic [7:0] f, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [4:0] en,
                       input logic [3:0] fl, input logic [1:0] st, input logic flt);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, imem_ready, id_uses_rs1, id_uses_rs2,
         ex_mem_read, ex_branch_taken, mem_req, mem_ack} = f;
        id_rs1 = r1;
        id_rs2 = r2;
        ex_rd  = rd;
        e.name     = nm;
        e.v        = {en, fl, st, flt};
        e.chk_perf = 1'b0;
        e.p_stall  = '0;
        e.p_flush  = '0;
        e.p_mw     = '0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [11:0] act;
            e   = q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, state_o, mem_fault};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: en/flush/state/fault got %b_%b_%b_%b expected %b_%b_%b_%b",
                         e.name, act[11:7], act[6:3], act[2:1], act[0],
                         e.v[11:7], e.v[6:3], e.v[2:1], e.v[0]);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (e.chk_perf) begin
                checks++;
                if (perf_stall_cycles !== e.p_stall || perf_flush_events !== e.p_flush ||
                    perf_mem_wait_cycles !== e.p_mw) begin
                    errors++;
                    $display("FAIL %s_perf: stall/flush/mw got %0d/%0d/%0d expected %0d/%0d/%0d",
                             e.name, perf_stall_cycles, perf_flush_events, perf_mem_wait_cycles,
                             e.p_stall, e.p_flush, e.p_mw);
                end
            end
`endif
        end
    end

    initial begin
        {reset, imem_ready, id_uses_rs1, id_uses_rs2,
         ex_mem_read, ex_branch_taken, mem_req, mem_ack} = F_RST | F_IR;
        id_rs1 = '0;
        id_rs2 = '0;
        ex_rd  = '0;

        vec("rst0",      F_RST | F_IR, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 0);
        vec("rst1",      F_RST | F_IR, 0, 0, 0, 5'b00000, 4'b0000, 2'd0, 0);
        vec("idle",      F_IR,         0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);

        // load-use
        vec("lu_rs1",    F_IR | F_U1 | F_MR, 5, 0, 5, 5'b00111, 4'b0100, 2'd0, 0);
        vec("lu_done",   F_IR,               0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);
        vec("lu_rd0",    F_IR | F_U1 | F_MR, 0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);
        vec("lu_rs2",    F_IR | F_U2 | F_MR, 0, 7, 7, 5'b00111, 4'b0100, 2'd0, 0);
        vec("lu_nouse",  F_IR | F_MR,        7, 0, 7, 5'b11111, 4'b0000, 2'd0, 0);
        vec("lu_noload", F_IR | F_U1,        7, 0, 7, 5'b11111, 4'b0000, 2'd0, 0);
        vec("lu_fetch",  F_U1 | F_MR,        3, 0, 3, 5'b00111, 4'b0100, 2'd0, 0);

        // memory handshake
        vec("req_ack",   F_IR | F_RQ | F_AK, 0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);
        vec("mw_run",    F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd0, 0);
        vec("mw_w1",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("mw_w2",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("mw_ack",    F_IR | F_RQ | F_AK, 0, 0, 0, 5'b11111, 4'b0000, 2'd1, 0);
        vec("mw_rel",    F_IR,               0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);

        // branch priority and branch held through a freeze
        vec("br_lu",     F_IR | F_BR | F_U1 | F_MR, 9, 0, 9, 5'b11111, 4'b1100, 2'd0, 0);
        vec("br_mw0",    F_IR | F_BR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd0, 0);
        vec("br_mw1",    F_IR | F_BR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("br_ack",    F_IR | F_BR | F_RQ | F_AK, 0, 0, 0, 5'b11111, 4'b1100, 2'd1, 0);
        vec("br_after",  F_IR,                      0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);

        // ack on the very cycle the count reaches the timeout: no fault
        vec("edge_run",  F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd0, 0);
        vec("edge_w1",   F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("edge_w2",   F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("edge_w3",   F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("edge_ack",  F_IR | F_RQ | F_AK, 0, 0, 0, 5'b11111, 4'b0000, 2'd1, 0);
        vec("edge_rel",  F_IR,               0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);

        // timeout into FAULT, then async reset out of it
        vec("to_run",    F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd0, 0);
        vec("to_w1",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("to_w2",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("to_w3",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("to_w4",     F_IR | F_RQ,        0, 0, 0, 5'b00000, 4'b0001, 2'd1, 0);
        vec("fault0",    F_IR,               0, 0, 0, 5'b00000, 4'b0000, 2'd2, 1);
        vec("fault_br",  F_IR | F_BR | F_AK, 0, 0, 0, 5'b00000, 4'b0000, 2'd2, 1);
        vec("rst_fault", F_RST | F_IR,       0, 0, 0, 5'b00000, 4'b0000, 2'd0, 0);
        vec("post_rst",  F_IR,               0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);

        // fetch wait
        vec("fw1",       8'h00,              0, 0, 0, 5'b01111, 4'b1000, 2'd0, 0);
        vec("fw2",       8'h00,              0, 0, 0, 5'b01111, 4'b1000, 2'd0, 0);
        vec("fw_end",    F_IR,               0, 0, 0, 5'b11111, 4'b0000, 2'd0, 0);
`ifdef PIPE_CTRL_PERF_EN
        q[q.size()-1].chk_perf = 1'b1;
        q[q.size()-1].p_stall  = 32'd2;
        q[q.size()-1].p_flush  = 32'd0;
        q[q.size()-1].p_mw     = 32'd0;
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB; each flush feeds the register's synchronous reset pin, so it inserts a bubble. It handles load-use hazards, taken-branch squash, instruction-fetch wait and a multi-cycle data-memory req/ack handshake with timeout. It sits beside the datapath in the core top level.

Parameters:
MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before fault (>=2)
PERF_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
imem_ready  in  1  fetch data valid this cycle
id_rs1, id_rs2  in  5 each  source regs of instruction in ID
id_uses_rs1, id_uses_rs2  in  1 each  instruction in ID reads rs1/rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination reg of instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  instruction in MEM accesses data memory
mem_ack  in  1  data memory completes access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  bubble insert (sync reset of stage register)
mem_fault  out  1  sticky memory timeout flag
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async): state=RUN, wait_cnt=0, mem_fault=0. While reset is high, all _en=0 and all _flush=0.
- FSM states: RUN=0, MEM_WAIT=1, FAULT=2. Enables and flushes are combinational from state and inputs, with no added latency. State, wait_cnt and mem_fault are registered.
- Default in RUN: all _en=1, all _flush=0.
- Priority in RUN, highest first: memory stall > branch flush > load-use > fetch wait.
- Memory stall: RUN with mem_req=1 and mem_ack=0 -> all _en=0 (full freeze), mem_wb_flush=1. Next state is MEM_WAIT, wait_cnt=1.
- mem_req=1 with mem_ack=1 in the same RUN cycle -> no stall.
- MEM_WAIT without ack: full freeze, mem_wb_flush=1, wait_cnt++.
- MEM_WAIT with mem_ack=1: outputs as RUN evaluation (branch/load-use/fetch rules apply), next state RUN, wait_cnt=0.
- MEM_WAIT timeout: wait_cnt==MEM_TIMEOUT with ack=0 -> next state FAULT, mem_fault<=1. A simultaneous ack wins; no fault.
- FAULT: all _en=0, all _flush=0. Held until reset; mem_fault stays 1.
- Branch (ex_branch_taken=1, no memory stall): pc_en=1, if_id_flush=1, id_ex_flush=1. Any load-use or fetch wait that cycle is ignored.
- Load-use: ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)) -> pc_en=0, if_id_en=0, id_ex_flush=1; EX/MEM and MEM/WB advance. Lasts exactly one cycle, because the load then leaves EX.
- Fetch wait (imem_ready=0, no higher event): pc_en=0, if_id_flush=1, rest advance.
- Load-use together with fetch wait: load-use outputs apply; if_id_flush=0 so IF/ID holds the stalled instruction.
- ex_branch_taken held during a freeze is re-evaluated on release, so the branch is acted on exactly once.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cycles[PERF_W], perf_flush_events[PERF_W] and perf_mem_wait_cycles[PERF_W], all reset to 0 and wrapping at 2^PERF_W.
  - perf_stall_cycles increments on any cycle with pc_en=0 (outside reset).
  - perf_flush_events increments on each branch flush.
  - perf_mem_wait_cycles increments each cycle in MEM_WAIT.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum pipe_state_t {RUN, MEM_WAIT, FAULT} (2-bit)
  - packed struct stage_ctrl_t {en[4:0], flush[3:0]}
  - REG_ZERO=5'd0
- One sub-module, load_use_detect (combinational compare, outputs hazard), instantiated once.

Test Plan:
1. Load x5 in EX, ID uses rs1=x5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all _en=1. Repeat with ex_rd=0 -> no stall.
2. mem_req=1, mem_ack low for 3 cycles then high -> 3 cycles of full freeze with mem_wb_flush=1, state_o=1; release cycle state_o->0 and enables=1.
3. ex_branch_taken together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1.
4. Branch taken during MEM_WAIT -> frozen, no flush; on ack cycle flush asserted exactly once.
5. mem_req=1, mem_ack never, MEM_TIMEOUT=4 -> FAULT after 4 wait cycles, mem_fault=1, all _en=0; assert reset mid-FAULT -> state RUN, mem_fault=0 immediately (async).
6. imem_ready=0 for 2 cycles -> pc_en=0, if_id_flush=1 for 2 cycles; with PIPE_CTRL_PERF_EN, perf_stall_cycles=2.
